pixy_spi_responder: RTL and testbench
=====================================

PIXY_SPI_RESPONDER -- requirements
Module: pixy_spi_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, TX word FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter IDLE_WORD, default 16'h0000, word shifted out when the TX FIFO is empty.
REQ-003 SHALL have ports: FAB_CLK  in  1  sole clock; FAB_RESET  in  1  synchronous, active-high reset.
REQ-004 SHALL have port SPI_CLK  in  1  SPI clock from MSS master, asynchronous to FAB_CLK, idle low.
REQ-005 SHALL have port SPI_SS  in  1  active-low slave select.
REQ-006 SHALL have port SPI_DI  in  1  master-out data.
REQ-007 SHALL have port SPI_DO  out  1  slave-out data.
REQ-008 SHALL have port SPI_DO_OE  out  1  output enable for the SPI_DO pad driver.
REQ-009 SHALL have ports TX_DATA  in  16  word to send; TX_VALID  in  1; TX_READY  out  1.
REQ-010 SHALL have port TX_LEVEL  out  5  current FIFO occupancy.
REQ-011 SHALL have ports RX_DATA  out  16  last received word; RX_VALID  out  1  one-cycle strobe.
REQ-012 SHALL have ports TX_UNDERRUN  out  1  one-cycle strobe; RX_SYNC  out  1  one-cycle strobe.

Function
REQ-013 SHALL pass SPI_CLK, SPI_SS, SPI_DI through two-flop FAB_CLK synchronizers plus one edge-detect register; FAB_CLK SHALL be >= 8x SPI_CLK.
REQ-014 SHALL implement SPI mode 0, 16-bit words, MSB first: sample SPI_DI on SPI_CLK rise, update SPI_DO on SPI_CLK fall.
REQ-015 SHALL use states IDLE (SS high), LOAD, SHIFT; IDLE->LOAD on synchronized SS fall, LOAD->SHIFT after one cycle, SHIFT->LOAD after the 16th rising edge's following falling edge, any state->IDLE on synchronized SS rise.
REQ-016 In LOAD SHALL pop the FIFO head into the TX shift register, or load IDLE_WORD and pulse TX_UNDERRUN if the FIFO is empty, and drive its MSB on SPI_DO.
REQ-017 SPI_DO_OE SHALL be 1 exactly while not IDLE; SPI_DO SHALL be 0 in IDLE.
REQ-018 On the 16th sampled rising edge SHALL update RX_DATA and pulse RX_VALID on the next FAB_CLK cycle.
REQ-019 SS deasserting before 16 bits SHALL discard the partial RX word (no RX_VALID), reset the bit counter to 0, and lose the popped TX word (no re-push).
REQ-020 TX_READY SHALL equal (TX_LEVEL != FIFO_DEPTH); push occurs on TX_VALID && TX_READY.
REQ-021 Simultaneous push and pop SHALL leave TX_LEVEL unchanged; a push into an empty FIFO in the same cycle as LOAD SHALL NOT bypass (IDLE_WORD sent, word retained).
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; TX_VALID while full SHALL be ignored without corruption.

Reset
REQ-023 FAB_RESET SHALL clear state to IDLE, FIFO pointers/TX_LEVEL to 0, RX_DATA to 0, SPI_DO/SPI_DO_OE/RX_VALID/TX_UNDERRUN/RX_SYNC to 0, TX_READY to 1 on the next FAB_CLK edge.
REQ-024 Reset asserted mid-word SHALL abort the transfer; after release, no activity SHALL start until a fresh synchronized SS falling edge.

Configuration
REQ-025 With macro PIXY_RX_SYNC_EN defined, RX_SYNC SHALL pulse in the same cycle as RX_VALID when the received word equals 16'h5A00 (Pixy sync byte, zero payload).
REQ-026 Without PIXY_RX_SYNC_EN, RX_SYNC SHALL be tied to 0 and no comparator SHALL be synthesized.

Verification
REQ-027 Push 0xAA55, 0x1234; SS low, 32 SCK with DI=0xBEEF,0x0042 -> DO shows 0xAA55 then 0x1234; RX_VALID twice with 0xBEEF, 0x0042; TX_LEVEL 2->0.
REQ-028 Empty FIFO, one 16-bit transfer -> DO = 0x0000, one TX_UNDERRUN pulse, RX_VALID once.
REQ-029 Push 9 words with TX_VALID held high -> TX_READY low after 8, TX_LEVEL = 8, 9th word not stored; drain 8 and confirm order.
REQ-030 SS raised after 7 bits, then full 16-bit transfer DI=0x00FF -> no RX_VALID for the aborted word, RX_DATA = 0x00FF, second word pulled from FIFO.
REQ-031 PIXY_RX_SYNC_EN defined, DI=0x5A00 then 0x5A01 -> RX_SYNC pulses once with first RX_VALID only; undefined -> RX_SYNC stays 0.
REQ-032 FAB_RESET asserted after 5 bits mid-word -> all outputs at reset values next cycle, SPI_DO_OE = 0, FIFO empty; next transfer after new SS fall sends IDLE_WORD.

Source files
------------

// File: rtl/pixy_spi_responder.sv
// SPI mode-0 slave responder: 16-bit MSB-first words, TX word FIFO, RX word strobe.
// Optional macro PIXY_RX_SYNC_EN adds the 16'h5A00 sync-word detector driving RX_SYNC.
module pixy_spi_responder #(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter logic [15:0] IDLE_WORD  = 16'h0000
) (
  input  logic        FAB_CLK,
  input  logic        FAB_RESET,
  input  logic        SPI_CLK,
  input  logic        SPI_SS,
  input  logic        SPI_DI,
  output logic        SPI_DO,
  output logic        SPI_DO_OE,
  input  logic [15:0] TX_DATA,
  input  logic        TX_VALID,
  output logic        TX_READY,
  output logic [4:0]  TX_LEVEL,
  output logic [15:0] RX_DATA,
  output logic        RX_VALID,
  output logic        TX_UNDERRUN,
  output logic        RX_SYNC
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT} state_t;

  state_t          state_q, state_d;
  logic [2:0]      sclk_q, ss_q;
  logic [1:0]      di_q;
  logic [15:0]     mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [4:0]      level_q;
  logic [15:0]     tx_sh_q, rx_sh_q, rx_data_q;
  logic [4:0]      bit_cnt_q;
  logic            rx_valid_q, tx_underrun_q;

  logic            sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic            fifo_empty, push, pop, rx_done;
  logic [15:0]     load_word, rx_word;

  // [1] is the synchronized level, [2] the previous level for edge detection
  assign sclk_rise  = sclk_q[1] & ~sclk_q[2];
  assign sclk_fall  = ~sclk_q[1] & sclk_q[2];
  assign ss_rise    = ss_q[1] & ~ss_q[2];
  assign ss_fall    = ~ss_q[1] & ss_q[2];

  assign fifo_empty = (level_q == '0);
  assign TX_READY   = (level_q != 5'(FIFO_DEPTH));
  assign push       = TX_VALID & TX_READY;
  assign pop        = (state_q == LOAD) & ~fifo_empty;
  assign load_word  = fifo_empty ? IDLE_WORD : mem_q[rd_ptr_q];
  assign rx_word    = {rx_sh_q[14:0], di_q[1]};
  assign rx_done    = (state_q == SHIFT) & sclk_rise & (bit_cnt_q == 5'd15);

  // Sync flops reset low so an SS already low at reset release is not seen as a fall
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      sclk_q <= '0;
      ss_q   <= '0;
      di_q   <= '0;
    end else begin
      sclk_q <= {sclk_q[1:0], SPI_CLK};
      ss_q   <= {ss_q[1:0], SPI_SS};
      di_q   <= {di_q[0], SPI_DI};
    end
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (ss_fall) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (sclk_fall && bit_cnt_q == 5'd16) state_d = LOAD;
      default: state_d = IDLE;
    endcase
    if (ss_rise) state_d = IDLE;
  end

  always_ff @(posedge FAB_CLK) begin
    if (push) mem_q[wr_ptr_q] <= TX_DATA;
  end

  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      level_q       <= '0;
      tx_sh_q       <= '0;
      rx_sh_q       <= '0;
      rx_data_q     <= '0;
      bit_cnt_q     <= '0;
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
    end else begin
      rx_valid_q    <= 1'b0;
      tx_underrun_q <= 1'b0;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + 5'd1;
      else if (pop && !push) level_q <= level_q - 5'd1;

      if (state_q == LOAD) begin
        tx_sh_q       <= load_word;
        tx_underrun_q <= fifo_empty;
        bit_cnt_q     <= '0;
      end else if (state_q == SHIFT) begin
        if (sclk_rise && bit_cnt_q < 5'd16) begin
          rx_sh_q   <= rx_word;
          bit_cnt_q <= bit_cnt_q + 5'd1;
        end
        if (rx_done) begin
          rx_data_q  <= rx_word;
          rx_valid_q <= 1'b1;
        end
        // The fall after bit 16 is consumed by LOAD, which reloads the register
        if (sclk_fall && bit_cnt_q != 5'd0 && bit_cnt_q != 5'd16)
          tx_sh_q <= {tx_sh_q[14:0], 1'b0};
      end
      if (ss_rise) bit_cnt_q <= '0;
    end
  end

`ifdef PIXY_RX_SYNC_EN
  logic rx_sync_q;
  always_ff @(posedge FAB_CLK) begin
    if (FAB_RESET) rx_sync_q <= 1'b0;
    else           rx_sync_q <= rx_done && (rx_word == 16'h5A00);
  end
  assign RX_SYNC = rx_sync_q;
`else
  assign RX_SYNC = 1'b0;
`endif

  assign SPI_DO_OE   = (state_q != IDLE);
  assign SPI_DO      = (state_q == LOAD)  ? load_word[15] :
                       (state_q == SHIFT) ? tx_sh_q[15] : 1'b0;
  assign TX_LEVEL    = level_q;
  assign RX_DATA     = rx_data_q;
  assign RX_VALID    = rx_valid_q;
  assign TX_UNDERRUN = tx_underrun_q;

endmodule

// File: tb/tb_pixy_spi_responder.sv
// Bench for pixy_spi_responder: directed table, corner sequences and random sessions vs a queue model.
module tb_pixy_spi_responder;

  localparam int unsigned DEPTH  = 8;
  localparam logic [15:0] IDLE_W = 16'h0000;
  localparam int          HALF   = 10;

  logic        FAB_CLK, FAB_RESET, SPI_CLK, SPI_SS, SPI_DI, SPI_DO, SPI_DO_OE;
  logic [15:0] TX_DATA, RX_DATA;
  logic        TX_VALID, TX_READY, RX_VALID, TX_UNDERRUN, RX_SYNC;
  logic [4:0]  TX_LEVEL;

  pixy_spi_responder #(.FIFO_DEPTH(DEPTH), .IDLE_WORD(IDLE_W)) dut (
    .FAB_CLK(FAB_CLK), .FAB_RESET(FAB_RESET), .SPI_CLK(SPI_CLK), .SPI_SS(SPI_SS),
    .SPI_DI(SPI_DI), .SPI_DO(SPI_DO), .SPI_DO_OE(SPI_DO_OE), .TX_DATA(TX_DATA),
    .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_LEVEL(TX_LEVEL), .RX_DATA(RX_DATA),
    .RX_VALID(RX_VALID), .TX_UNDERRUN(TX_UNDERRUN), .RX_SYNC(RX_SYNC)
  );

  initial FAB_CLK = 1'b0;
  always #5 FAB_CLK = ~FAB_CLK;

  int          checks, errors;
  int          under_cnt, exp_under, sync_cnt, exp_sync;
  logic [15:0] model_q [$];
  logic [15:0] rx_q [$];
  logic [15:0] exp_rx [$];
  logic [15:0] mosi_w [16];
  logic [15:0] miso_w [16];

  typedef struct {
    bit          push;
    logic [15:0] txw;
    logic [15:0] mosi;
    logic [15:0] exp_miso;
    int          exp_und;
  } vec_t;
  vec_t tbl [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge FAB_CLK) begin
    if (!FAB_RESET) begin
      if (RX_VALID)    rx_q.push_back(RX_DATA);
      if (TX_UNDERRUN) under_cnt++;
      if (RX_SYNC)     sync_cnt++;
    end
  end

  function automatic logic [15:0] model_pop();
    if (model_q.size() > 0) return model_q.pop_front();
    exp_under++;
    return IDLE_W;
  endfunction

  task automatic push_word(input logic [15:0] w);
    @(negedge FAB_CLK);
    check("tx_ready", 32'(TX_READY), 32'(model_q.size() != DEPTH));
    TX_DATA  = w;
    TX_VALID = 1'b1;
    if (model_q.size() < DEPTH) model_q.push_back(w);
    @(negedge FAB_CLK);
    TX_VALID = 1'b0;
    check("tx_level_push", 32'(TX_LEVEL), 32'(model_q.size()));
  endtask

  task automatic ss_low();
    @(negedge FAB_CLK);
    SPI_SS = 1'b0;
    repeat (HALF) @(negedge FAB_CLK);
  endtask

  // Master side of mode 0; when last is set SS rises together with the final SCK fall
  task automatic xfer(input logic [15:0] mosi, input int nbits, input bit last,
                      output logic [15:0] miso);
    miso = '0;
    for (int i = 0; i < nbits; i++) begin
      SPI_DI = mosi[15-i];
      repeat (HALF) @(negedge FAB_CLK);
      SPI_CLK = 1'b1;
      miso[15-i] = SPI_DO;
      repeat (HALF) @(negedge FAB_CLK);
      SPI_CLK = 1'b0;
      if (last && i == nbits - 1) SPI_SS = 1'b1;
    end
  endtask

  task automatic run_session(input int nw, input int abort_bits);
    logic [15:0] exp_tx;
    int bits;
    ss_low();
    check("oe_active", 32'(SPI_DO_OE), 32'd1);
    exp_tx = model_pop();
    for (int w = 0; w < nw; w++) begin
      bits = (w == nw - 1 && abort_bits > 0) ? abort_bits : 16;
      xfer(mosi_w[w], bits, w == nw - 1, miso_w[w]);
      if (bits == 16) begin
        check("miso_word", 32'(miso_w[w]), 32'(exp_tx));
        exp_rx.push_back(mosi_w[w]);
`ifdef PIXY_RX_SYNC_EN
        if (mosi_w[w] == 16'h5A00) exp_sync++;
`endif
        if (w != nw - 1) exp_tx = model_pop();
      end
    end
    repeat (2*HALF) @(negedge FAB_CLK);
    check("oe_idle", 32'(SPI_DO_OE), 32'd0);
    check("do_idle", 32'(SPI_DO), 32'd0);
    check("rx_count", 32'(rx_q.size()), 32'(exp_rx.size()));
    for (int k = 0; k < exp_rx.size() && k < rx_q.size(); k++)
      check("rx_word", 32'(rx_q[k]), 32'(exp_rx[k]));
    check("underruns", 32'(under_cnt), 32'(exp_under));
    check("rx_sync", 32'(sync_cnt), 32'(exp_sync));
    check("tx_level", 32'(TX_LEVEL), 32'(model_q.size()));
    rx_q.delete();
    exp_rx.delete();
  endtask

  initial begin
    logic [15:0] tmpw;
    int u0, s0, np, nw, ab;
    checks = 0; errors = 0;
    under_cnt = 0; exp_under = 0; sync_cnt = 0; exp_sync = 0;
    FAB_RESET = 1'b1; SPI_SS = 1'b1; SPI_CLK = 1'b0; SPI_DI = 1'b0;
    TX_VALID = 1'b0; TX_DATA = '0;

    tbl[0] = '{1'b1, 16'h1357, 16'hBEEF, 16'h1357, 0};
    tbl[1] = '{1'b0, 16'h0000, 16'h0F0F, 16'h0000, 1};
    tbl[2] = '{1'b1, 16'hFFFF, 16'h8001, 16'hFFFF, 0};
    tbl[3] = '{1'b1, 16'h8000, 16'h5A00, 16'h8000, 0};

    repeat (3) @(negedge FAB_CLK);
    check("rst_do",       32'(SPI_DO),      32'd0);
    check("rst_oe",       32'(SPI_DO_OE),   32'd0);
    check("rst_level",    32'(TX_LEVEL),    32'd0);
    check("rst_ready",    32'(TX_READY),    32'd1);
    check("rst_rxdata",   32'(RX_DATA),     32'd0);
    check("rst_rxvalid",  32'(RX_VALID),    32'd0);
    check("rst_underrun", 32'(TX_UNDERRUN), 32'd0);
    check("rst_sync",     32'(RX_SYNC),     32'd0);
    FAB_RESET = 1'b0;
    repeat (5) @(negedge FAB_CLK);

    for (int t = 0; t < 4; t++) begin
      u0 = under_cnt;
      if (tbl[t].push) push_word(tbl[t].txw);
      mosi_w[0] = tbl[t].mosi;
      run_session(1, 0);
      check("tbl_miso", 32'(miso_w[0]), 32'(tbl[t].exp_miso));
      check("tbl_underrun", 32'(under_cnt - u0), 32'(tbl[t].exp_und));
    end

    // Two back-to-back words
    push_word(16'hAA55);
    push_word(16'h1234);
    check("two_level", 32'(TX_LEVEL), 32'd2);
    mosi_w[0] = 16'hBEEF; mosi_w[1] = 16'h0042;
    run_session(2, 0);
    check("two_do0", 32'(miso_w[0]), 32'hAA55);
    check("two_do1", 32'(miso_w[1]), 32'h1234);
    check("two_level_end", 32'(TX_LEVEL), 32'd0);

    // Fill past full with TX_VALID held
    for (int i = 0; i < 9; i++) begin
      @(negedge FAB_CLK);
      check("fill_ready", 32'(TX_READY), 32'(i < 8));
      TX_DATA  = 16'h1100 + 16'(i);
      TX_VALID = 1'b1;
      if (model_q.size() < DEPTH) model_q.push_back(TX_DATA);
    end
    @(negedge FAB_CLK);
    TX_VALID = 1'b0;
    check("full_level", 32'(TX_LEVEL), 32'd8);
    check("full_ready", 32'(TX_READY), 32'd0);
    for (int w = 0; w < 8; w++) mosi_w[w] = 16'h0100 + 16'(w);
    run_session(8, 0);
    for (int w = 0; w < 8; w++) check("drain_order", 32'(miso_w[w]), 32'h1100 + 32'(w));

    // Abort after 7 bits, then a full word
    push_word(16'h7777);
    push_word(16'h2468);
    mosi_w[0] = 16'hFFFF;
    run_session(1, 7);
    mosi_w[0] = 16'h00FF;
    run_session(1, 0);
    check("abort_next_do", 32'(miso_w[0]), 32'h2468);
    check("abort_rxdata",  32'(RX_DATA),   32'h00FF);

    // Sync word detection
    s0 = sync_cnt;
    mosi_w[0] = 16'h5A00; mosi_w[1] = 16'h5A01;
    run_session(2, 0);
`ifdef PIXY_RX_SYNC_EN
    check("sync_pulses", 32'(sync_cnt - s0), 32'd1);
`else
    check("sync_pulses", 32'(sync_cnt - s0), 32'd0);
`endif

    // Reset mid-word
    push_word(16'hABCD);
    push_word(16'h1111);
    ss_low();
    tmpw = model_pop();
    xfer(16'h1F1F, 5, 1'b0, tmpw);
    @(negedge FAB_CLK);
    FAB_RESET = 1'b1;
    @(negedge FAB_CLK);
    check("mrst_oe",       32'(SPI_DO_OE),   32'd0);
    check("mrst_do",       32'(SPI_DO),      32'd0);
    check("mrst_level",    32'(TX_LEVEL),    32'd0);
    check("mrst_ready",    32'(TX_READY),    32'd1);
    check("mrst_rxdata",   32'(RX_DATA),     32'd0);
    check("mrst_rxvalid",  32'(RX_VALID),    32'd0);
    check("mrst_underrun", 32'(TX_UNDERRUN), 32'd0);
    FAB_RESET = 1'b0;
    model_q.delete();
    xfer(16'hFFFF, 11, 1'b0, tmpw);
    check("mrst_no_start", 32'(SPI_DO_OE), 32'd0);
    check("mrst_no_rx", 32'(rx_q.size()), 32'd0);
    @(negedge FAB_CLK);
    SPI_SS = 1'b1;
    repeat (2*HALF) @(negedge FAB_CLK);
    mosi_w[0] = 16'h0F0F;
    run_session(1, 0);
    check("mrst_idle_word", 32'(miso_w[0]), 32'(IDLE_W));

    // Random sessions against the queue model
    for (int s = 0; s < 20; s++) begin
      np = int'($urandom_range(0, 10));
      for (int p = 0; p < np; p++) push_word(16'($urandom));
      nw = int'($urandom_range(1, 4));
      ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 0;
      for (int w = 0; w < nw; w++)
        mosi_w[w] = ($urandom_range(0, 7) == 0) ? 16'h5A00 : 16'($urandom);
      run_session(nw, ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
